// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and scanning modes.
// Drives multiplexed displays and round-robin chip selects.
module scan_decoder #(
  parameter int AW      = 4,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                E,
  input  logic                mode,
  input  logic                load,
  input  logic [AW-1:0]       a,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**AW-1:0]    D,
  output logic [AW-1:0]       idx,
  output logic                wrap
);

  localparam int NOUT = 2**AW;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [AW-1:0]      nxt;

  function automatic logic [NOUT-1:0] hot(
    input logic [AW-1:0] i
  );
    logic [NOUT-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign nxt = idx + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      D     <= '0;
      idx   <= '0;
      cnt   <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (1'b1)
        !E: begin
          state <= IDLE;
          D     <= '0;
          cnt   <= '0;
          if (load) idx <= a;
        end
        E && !mode: begin
          state <= DIRECT;
          cnt   <= '0;
          if (load) begin
            idx <= a;
            D   <= hot(a);
          end else begin
            D <= hot(idx);
          end
        end
        E && mode: begin
          state <= SCAN;
          if (load) begin
            idx <= a;
            cnt <= '0;
            D   <= hot(a);
          end else if (state != SCAN) begin
            // entering scan: current line starts a fresh dwell
            cnt <= '0;
            D   <= hot(idx);
          end else if (cnt == dwell) begin
            cnt  <= '0;
            idx  <= nxt;
            D    <= hot(nxt);
            wrap <= &idx;
          end else begin
            cnt <= cnt + DWELL_W'(1);
            D   <= hot(idx);
          end
        end
        default: begin
          state <= IDLE;
          D     <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
